// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if: bus between memory reader/feeder (master) and the window feeder (slave).
// Carries start, the serial weight stream, the pixel stream, the conv core's valid,
// and the feeder's window/weight/bias outputs plus busy/done status.
interface conv_window_feeder_if #(
  parameter int IMA = 8,
  parameter int DATA = 16,
  parameter int NUM = 49
);
  logic start;
  logic [DATA-1:0] wei_in;
  logic wei_valid;
  logic wei_ready;
  logic [IMA-1:0] pix_in;
  logic pix_valid;
  logic pix_ready;
  logic conv_valid;
  logic enable;
  logic [IMA*NUM-1:0] ima;
  logic [DATA*NUM-1:0] wei;
  logic [DATA-1:0] bias;
  logic busy;
  logic done;
  modport master (
    output start, wei_in, wei_valid, pix_in, pix_valid, conv_valid,
    input wei_ready, pix_ready, enable, ima, wei, bias, busy, done
  );
  modport slave (
    input start, wei_in, wei_valid, pix_in, pix_valid, conv_valid,
    output wei_ready, pix_ready, enable, ima, wei, bias, busy, done
  );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: loads 7x7 weights/bias, builds stride-1 7x7 windows from a raster pixel stream.
// Ports: clk, rst (sync, active-high), bus (slave): start, wei_in/valid/ready,
// pix_in/valid/ready, conv_valid in; enable, ima, wei, bias, busy, done out.
module conv_window_feeder #(
  parameter int IMA = 8,
  parameter int DATA = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input logic clk,
  input logic rst,
  conv_window_feeder_if.slave bus
);
  localparam int NUM = 49;
  localparam int TOTAL = (IMG_W - 6) * (IMG_H - 6);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int OW = $clog2(TOTAL + 1);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [5:0] load_cnt;
  logic [OW-1:0] out_cnt;
  logic [IMA-1:0] lb [6][IMG_W];
  logic [IMA*NUM-1:0] win, win_nx;
  logic ld, acc, col_last, last_pix, fire;
  assign ld = bus.wei_valid & bus.wei_ready;
  assign acc = bus.pix_valid & bus.pix_ready;
  assign col_last = int'(col) == IMG_W - 1;
  assign last_pix = col_last && int'(row) == IMG_H - 1;
  assign fire = acc && int'(row) >= 6 && int'(col) >= 6;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? LOAD : IDLE;
      LOAD: state_nx = ld && load_cnt == 6'd49 ? STREAM : LOAD;
      STREAM: state_nx = acc && last_pix ? DRAIN : STREAM;
      DRAIN: state_nx = int'(out_cnt) >= TOTAL ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // Window shifts left; the new right column is the buffered column (oldest row on top) plus pix_in.
  always_comb begin
    win_nx = win;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 6; c++)
        win_nx[(r*7+c)*IMA +: IMA] = win[(r*7+c+1)*IMA +: IMA];
    for (int r = 0; r < 6; r++)
      win_nx[(r*7+6)*IMA +: IMA] = lb[r][col];
    win_nx[48*IMA +: IMA] = bus.pix_in;
  end
  always_ff @(posedge clk)
    if (acc) begin
      for (int r = 0; r < 5; r++)
        lb[r][col] <= lb[r+1][col];
      lb[5][col] <= bus.pix_in;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.enable <= 1'b0;
      bus.done <= 1'b0;
      bus.wei_ready <= 1'b0;
      bus.pix_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.ima <= '0;
      bus.wei <= '0;
      bus.bias <= '0;
      win <= '0;
      col <= '0;
      row <= '0;
      load_cnt <= '0;
      out_cnt <= '0;
    end else begin
      state <= state_nx;
      bus.wei_ready <= state_nx == LOAD;
      bus.pix_ready <= state_nx == STREAM;
      bus.busy <= state_nx != IDLE;
      bus.done <= state == DRAIN && state_nx == IDLE;
      bus.enable <= fire;
      if (fire) bus.ima <= win_nx;
      if (state == IDLE && bus.start) begin
        col <= '0;
        row <= '0;
        load_cnt <= '0;
        out_cnt <= '0;
      end
      if (ld) begin
        if (load_cnt == 6'd49) bus.bias <= bus.wei_in;
        else bus.wei[int'(load_cnt)*DATA +: DATA] <= bus.wei_in;
        load_cnt <= load_cnt + 6'd1;
      end
      if (acc) begin
        win <= win_nx;
        col <= col_last ? '0 : col + 1'b1;
        row <= col_last ? row + 1'b1 : row;
      end
      if (bus.conv_valid && (state == STREAM || state == DRAIN)) out_cnt <= out_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: checks 8x8 and 28x28 feeders against an image-array window model.
module tb_conv_window_feeder;
  typedef struct { int tap; int exp; } tv_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  conv_window_feeder_if a ();
  conv_window_feeder_if b ();
  conv_window_feeder #(.IMG_W(8), .IMG_H(8)) dut8 (.clk(clk), .rst(rst), .bus(a));
  conv_window_feeder dut28 (.clk(clk), .rst(rst), .bus(b));
  int tests = 0;
  int fails = 0;
  int img[784];
  int w[50];
  bit [9:0] sra, srb;
  int cva, cvb;
  logic [391:0] first_ima;
  int br[$];
  tv_t tv_first[4], tv_wei[3], tv_br[4];
  task automatic chk(input string name, input logic [783:0] act, input logic [783:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // conv_valid models the core: each enable comes back 10 cycles later.
  task automatic tick();
    if (a.conv_valid) cva++;
    if (b.conv_valid) cvb++;
    @(posedge clk);
    #1;
    a.conv_valid = sra[9];
    sra = {sra[8:0], a.enable === 1'b1};
    b.conv_valid = srb[9];
    srb = {srb[8:0], b.enable === 1'b1};
  endtask
  function automatic logic [391:0] win_exp(input int iw, input int p);
    logic [391:0] v;
    int pr, pc;
    pr = p / iw;
    pc = p % iw;
    for (int t = 0; t < 49; t++) v[t*8 +: 8] = 8'(img[(pr - 6 + t / 7) * iw + pc - 6 + t % 7]);
    return v;
  endfunction
  task automatic frame8(input bit ramp, input int vpct, input bit abort);
    int p, k, nd, cyc;
    bit v, ee;
    logic [783:0] wexp;
    p = 0; k = 0; nd = 0; cyc = 0; wexp = '0;
    br.delete();
    for (int i = 0; i < 64; i++) img[i] = ramp ? i : int'($urandom_range(255));
    for (int i = 0; i < 50; i++) w[i] = ramp ? 'h100 + i : int'($urandom_range(65535));
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    chk("wei_ready_after_start", a.wei_ready, 1);
    chk("busy_after_start", a.busy, 1);
    while (k < 50) begin
      v = 1'($urandom_range(1));
      a.wei_valid = v;
      a.wei_in = 16'(w[k]);
      tick();
      k += int'(v);
    end
    a.wei_valid = 1'b0;
    for (int i = 0; i < 49; i++) wexp[i*16 +: 16] = 16'(w[i]);
    chk("wei", a.wei, wexp);
    chk("bias", a.bias, 16'(w[49]));
    chk("wei_ready_after_load", a.wei_ready, 0);
    cva = 0;
    while (p < 64 && cyc < 1000) begin
      if (abort && p == 20) break;
      chk("pix_ready", a.pix_ready, 1);
      v = vpct >= 100 || $urandom_range(99) < vpct;
      a.pix_valid = v;
      a.pix_in = 8'(img[p]);
      tick();
      cyc++;
      ee = v && p / 8 >= 6 && p % 8 >= 6;
      chk("enable", a.enable, ee);
      chk("done_early", a.done, 0);
      if (a.enable && ee) begin
        chk("window", a.ima, win_exp(8, p));
        if (br.size() == 0) first_ima = a.ima;
        br.push_back(int'(a.ima[391:384]));
      end
      p += int'(v);
    end
    a.pix_valid = 1'b0;
    if (abort) begin
      rst = 1'b1;
      tick();
      chk("abort_busy", a.busy, 0);
      chk("abort_pix_ready", a.pix_ready, 0);
      tick();
      rst = 1'b0;
      repeat (30) begin
        tick();
        chk("abort_no_done", a.done, 0);
      end
      chk("abort_idle", a.busy, 0);
      return;
    end
    chk("frame_complete", p, 64);
    chk("pix_ready_drain", a.pix_ready, 0);
    repeat (40) begin
      tick();
      if (a.done) begin
        nd++;
        chk("cv_at_done", cva, 4);
        chk("busy_at_done", a.busy, 0);
      end
    end
    chk("done_count", nd, 1);
    chk("busy_end", a.busy, 0);
  endtask
  task automatic frame28();
    int nen, nd;
    bit ee;
    nen = 0; nd = 0;
    for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(255));
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      b.wei_valid = 1'b1;
      b.wei_in = 16'(k);
      tick();
    end
    b.wei_valid = 1'b0;
    chk("pix_ready28", b.pix_ready, 1);
    cvb = 0;
    for (int p = 0; p < 784; p++) begin
      b.pix_valid = 1'b1;
      b.pix_in = 8'(img[p]);
      tick();
      ee = p / 28 >= 6 && p % 28 >= 6;
      chk("enable28", b.enable, ee);
      if (b.enable && ee) begin
        nen++;
        chk("window28", b.ima, win_exp(28, p));
      end
    end
    b.pix_valid = 1'b0;
    chk("enables28", nen, 484);
    repeat (40) begin
      tick();
      if (b.done) begin
        nd++;
        chk("cv_at_done28", cvb, 484);
      end
    end
    chk("done_count28", nd, 1);
    chk("busy_end28", b.busy, 0);
  endtask
  initial begin
    tv_first[0] = '{0, 0};
    tv_first[1] = '{6, 6};
    tv_first[2] = '{42, 48};
    tv_first[3] = '{48, 54};
    tv_wei[0] = '{0, 'h100};
    tv_wei[1] = '{48, 'h130};
    tv_wei[2] = '{49, 'h131};
    tv_br[0] = '{0, 54};
    tv_br[1] = '{1, 55};
    tv_br[2] = '{2, 62};
    tv_br[3] = '{3, 63};
    {a.start, a.wei_in, a.wei_valid, a.pix_in, a.pix_valid, a.conv_valid} = '0;
    {b.start, b.wei_in, b.wei_valid, b.pix_in, b.pix_valid, b.conv_valid} = '0;
    rst = 1'b1;
    repeat (3) begin
      a.start = 1'($urandom_range(1));
      a.wei_valid = 1'($urandom_range(1));
      a.wei_in = 16'($urandom);
      a.pix_valid = 1'($urandom_range(1));
      a.pix_in = 8'($urandom);
      tick();
      chk("rst_enable", a.enable, 0);
      chk("rst_done", a.done, 0);
      chk("rst_wei_ready", a.wei_ready, 0);
      chk("rst_pix_ready", a.pix_ready, 0);
      chk("rst_busy", a.busy, 0);
      chk("rst_ima", a.ima, 0);
      chk("rst_wei", a.wei, 0);
      chk("rst_bias", a.bias, 0);
    end
    {a.start, a.wei_in, a.wei_valid, a.pix_in, a.pix_valid} = '0;
    rst = 1'b0;
    tick();
    chk("idle_busy", a.busy, 0);
    frame8(1'b1, 100, 1'b0);
    foreach (tv_first[i])
      chk($sformatf("first_tap%0d", tv_first[i].tap), first_ima[tv_first[i].tap*8 +: 8], 8'(tv_first[i].exp));
    foreach (tv_wei[i])
      chk($sformatf("wei_tap%0d", tv_wei[i].tap),
          tv_wei[i].tap == 49 ? a.bias : a.wei[tv_wei[i].tap*16 +: 16], 16'(tv_wei[i].exp));
    frame8(1'b1, 50, 1'b0);
    chk("enables_50pct", br.size(), 4);
    foreach (tv_br[i])
      if (tv_br[i].tap < br.size())
        chk($sformatf("br_tap_win%0d", tv_br[i].tap), br[tv_br[i].tap], tv_br[i].exp);
      else
        chk($sformatf("br_tap_win%0d_missing", tv_br[i].tap), 0, tv_br[i].exp);
    frame8(1'b0, 50, 1'b1);
    frame8(1'b0, 50, 1'b0);
    frame28();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Drives the 7x7 convolution core: loads 49 signed 16-bit weights plus the bias serially.
- Accepts a raster-order 8-bit pixel stream and emits, one per accepted pixel, each complete stride-1 7x7 window on ima with a one-cycle enable.
- Counts the core's valid responses to report frame completion (done).
- Sits between the image/weight memory reader and the conv core.

Parameters:
IMA, 8, pixel width (unsigned)
DATA, 16, weight/bias width (signed, Q8.8)
IMG_W, 28, image width in pixels (>=7)
IMG_H, 28, image height in pixels (>=7)
NUM, 49, taps per window (fixed 7x7; not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a frame; honoured only in IDLE
wei_in  in  DATA  serial weight/bias word
wei_valid  in  1  wei_in valid
wei_ready  out  1  high in LOAD
pix_in  in  IMA  pixel, raster order (row 0 col 0 first)
pix_valid  in  1  pix_in valid
pix_ready  out  1  high in STREAM
conv_valid  in  1  valid from conv core
enable  out  1  window-valid strobe to conv core
ima  out  IMA*NUM  window; tap t=r*7+c at [t*8+7:t*8], r=0 top row, c=0 left column
wei  out  DATA*NUM  weights; tap t at [t*16+15:t*16]
bias  out  DATA  bias
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (synchronous, rst=1): state IDLE; enable, done, wei_ready, pix_ready, busy = 0; ima, wei, bias, window registers, row/col/load/output counters = 0. Line-buffer storage is not reset. Reset mid-frame abandons the frame immediately; no done pulse.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: each cycle with wei_valid=1 stores wei_in. Words 0..48 go to tap 0..48; word 49 goes to bias. After word 49 -> STREAM.
  - STREAM: accepts a pixel when pix_valid & pix_ready. After accepting the pixel at row IMG_H-1, col IMG_W-1 -> DRAIN.
  - DRAIN: pix_ready=0. When out_cnt reaches (IMG_W-6)*(IMG_H-6) -> done=1 for one cycle, then IDLE.
- Handshake: a transfer occurs only when valid & ready are both 1 in the same cycle. Inputs with ready=0 are ignored. start outside IDLE is ignored.
- Window construction:
  - Six line buffers, depth IMG_W, hold the previous six rows.
  - On each accepted pixel at column col, the 7x7 window shifts left one column.
  - New right column: rows 0..5 come from line buffers (oldest row at r=0) at address col; row 6 is pix_in.
  - The line buffers then shift that column up, storing pix_in.
- Enable/latency: if the accepted pixel has row>=6 and col>=6, then on the next cycle enable=1 and ima holds the window whose bottom-right tap (t=48) is that pixel. Otherwise enable=0. ima holds its value between enables.
  - Windows never straddle rows, because enable requires col>=6.
  - Maximum rate is one enable per cycle. There is no backpressure from the core.
- Counters:
  - col wraps IMG_W-1 -> 0 and increments row.
  - out_cnt increments on conv_valid in STREAM or DRAIN; conv_valid in IDLE/LOAD is ignored.
  - An accept and a conv_valid in the same cycle update their separate counters independently.
- wei and bias are stable from end of LOAD until the next LOAD.
- The core's 10-cycle latency is covered by DRAIN. done occurs at least 10 cycles after the last enable.

Test Plan:
- Reset/idle: assert rst with random inputs -> all outputs 0, wei_ready=pix_ready=0; start pulse -> wei_ready=1 next cycle, busy=1.
- Weight load: words 0x0100+k for k=0..49 -> wei tap 0=0x0100, tap 48=0x0130, bias=0x0131; state STREAM, pix_ready=1. wei_valid gaps stall loading without loss.
- First window, IMG_W=IMG_H=8, pixel=row*8+col, pix_valid held high:
  - exactly one enable, on the cycle after pixel 54 (row 6, col 6) is accepted;
  - ima tap0=0, tap6=6, tap42=48, tap48=54.
- Full frame, IMG_W=IMG_H=8, pix_valid toggled 50%:
  - 4 enables; window bottom-right taps 54, 55, 62, 63;
  - no enable on a non-accept cycle.
- Drain/done, IMG_W=IMG_H=8, conv_valid = enable delayed 10 cycles: done pulses once after the 4th conv_valid, then IDLE with busy=0. With default 28x28: 484 enables, done after the 484th conv_valid.
- Abort: rst during STREAM after 20 pixels -> IDLE, no done. A following full frame produces correct windows.
